// File: rtl/stack_op_ctrl.sv
// stack_op_ctrl: PUSH/POP sequencer between decode, the 32x32 register bank (r31 = SP) and data memory
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_op_valid/o_op_ready          op handshake; i_op_type 0 = PUSH, 1 = POP; i_op_reg source/dest
//   o_busy, o_done, o_err, o_err_code
//                                  status; err_code 00 ok, 01 overflow, 10 underflow, 11 mem timeout
//   o_rb_readSP, o_rb_sr2, i_rb_sp_data, i_rb_src_data
//                                  register bank read side
//   o_rb_writeSP, o_rb_write_dataSP, o_rb_writeReg, o_rb_dr, o_rb_write_data
//                                  register bank write side
//   o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata, i_mem_ack
//                                  single req/ack data memory access
module stack_op_ctrl #(
    parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0F00,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic        i_op_type,
    input  logic [4:0]  i_op_reg,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_rb_readSP,
    output logic [4:0]  o_rb_sr2,
    input  logic [31:0] i_rb_sp_data,
    input  logic [31:0] i_rb_src_data,
    output logic        o_rb_writeSP,
    output logic [31:0] o_rb_write_dataSP,
    output logic        o_rb_writeReg,
    output logic [4:0]  o_rb_dr,
    output logic [31:0] o_rb_write_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_MEM, S_WB, S_DONE, S_ERR} state_t;
    state_t      r_state, w_next;
    logic        r_type;
    logic [4:0]  r_reg;
    logic [31:0] r_sp, r_src, r_rdata;
    logic [1:0]  r_code;
    logic [7:0]  r_cnt;
    logic [32:0] w_dec;
    logic        w_bad, w_tmo, w_reg_wr;
    logic [31:0] w_sp_dn;
    // 33-bit subtract so an SP below 4 shows up as a borrow instead of wrapping high
    assign w_dec    = {1'b0, i_rb_sp_data} - 33'd4;
    assign w_bad    = r_type ? (i_rb_sp_data >= STACK_TOP) : (w_dec[32] || w_dec[31:0] < STACK_LIMIT);
    assign w_tmo    = r_cnt == 8'(MEM_TIMEOUT - 1);
    assign w_sp_dn  = r_sp - 32'd4;
    // r0 is never written and r31 is loaded through the SP port instead
    assign w_reg_wr = r_type && r_reg != 5'd0 && r_reg != 5'd31;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_op_valid ? S_RD : S_IDLE;
            S_RD:    w_next = w_bad ? S_ERR : S_MEM;
            S_MEM:   w_next = i_mem_ack ? S_WB : (w_tmo ? S_ERR : S_MEM);
            S_WB:    w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_type  <= 1'b0;
            r_reg   <= '0;
            r_sp    <= '0;
            r_src   <= '0;
            r_rdata <= '0;
            r_code  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_op_valid) begin
                r_type <= i_op_type;
                r_reg  <= i_op_reg;
            end
            if (r_state == S_RD) begin
                r_sp  <= i_rb_sp_data;
                r_src <= i_rb_src_data;
                r_cnt <= '0;
                if (w_bad) r_code <= r_type ? 2'b10 : 2'b01;
            end
            if (r_state == S_MEM) begin
                if (i_mem_ack) r_rdata <= i_mem_rdata;
                else r_cnt <= r_cnt + 8'd1;
                if (!i_mem_ack && w_tmo) r_code <= 2'b11;
            end
            if (r_state == S_WB) r_code <= 2'b00;
        end
    end
    assign o_op_ready        = r_state == S_IDLE && !i_reset;
    assign o_busy            = r_state != S_IDLE;
    assign o_done            = r_state == S_DONE || r_state == S_ERR;
    assign o_err             = r_state == S_ERR;
    assign o_err_code        = r_code;
    assign o_rb_readSP       = r_state == S_RD;
    assign o_rb_sr2          = r_state == S_RD ? r_reg : 5'd0;
    assign o_rb_writeSP      = r_state == S_WB;
    assign o_rb_write_dataSP = r_state != S_WB ? 32'd0 : !r_type ? w_sp_dn : r_reg == 5'd31 ? r_rdata : r_sp + 32'd4;
    assign o_rb_writeReg     = r_state == S_WB && w_reg_wr;
    assign o_rb_dr           = o_rb_writeReg ? r_reg : 5'd0;
    assign o_rb_write_data   = o_rb_writeReg ? r_rdata : 32'd0;
    assign o_mem_req         = r_state == S_MEM;
    assign o_mem_we          = r_state == S_MEM && !r_type;
    assign o_mem_addr        = r_state != S_MEM ? 32'd0 : r_type ? r_sp : w_sp_dn;
    assign o_mem_wdata       = r_state == S_MEM ? r_src : 32'd0;
endmodule
